// File: rtl/ahb_ws_regbank_if.sv
// AHB-Lite bus bundle for the wait-state register bank.
// The master modport drives the address and data phases; the slave modport returns the response.
interface ahb_ws_regbank_if #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 32
);
    logic              hsel;
    logic              hready;
    logic [AWIDTH-1:0] haddr;
    logic              hwrite;
    logic [2:0]        hsize;
    logic [1:0]        htrans;
    logic [DWIDTH-1:0] hwdata;
    logic [DWIDTH-1:0] hrdata;
    logic              hreadyout;
    logic              hresp;

    modport master (
        output hsel, hready, haddr, hwrite, hsize, htrans, hwdata,
        input  hrdata, hreadyout, hresp
    );

    modport slave (
        input  hsel, hready, haddr, hwrite, hsize, htrans, hwdata,
        output hrdata, hreadyout, hresp
    );
endinterface

// File: rtl/ahb_ws_regbank.sv
// AHB-Lite responder with a register file, programmable wait states, a two-cycle
// ERROR response and a completed-transfer counter in the top register.
module ahb_ws_regbank #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 32,
    parameter int NREGS  = 16
) (
    input  logic             clk,
    input  logic             rst,
    ahb_ws_regbank_if.slave  bus
);
    localparam int IW = $clog2(NREGS);
    localparam logic [IW-1:0] WS_IDX  = {IW{1'b0}};
    localparam logic [IW-1:0] ACC_IDX = IW'(NREGS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } state_t;

    // Byte-lane enables for a legal (aligned, size <= word) transfer.
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] m;
        case (size)
            2'd0:    m = 4'b0001 << off;
            2'd1:    m = off[1] ? 4'b1100 : 4'b0011;
            2'd2:    m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] merge_lanes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  mask);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            r[8*i +: 8] = mask[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
        end
        return r;
    endfunction

    state_t            state_r;
    state_t            state_n;
    logic [3:0]        cnt_r;
    logic [3:0]        cnt_n;
    logic              pend_r;
    logic              pend_n;
    logic [IW-1:0]     idx_r;
    logic [3:0]        mask_r;
    logic              write_r;
    logic              hreadyout_r;
    logic              hresp_r;

    logic [3:0]        ws_r;
    logic [DWIDTH-1:0] acc_r;
    logic [DWIDTH-1:0] gp_r [NREGS];

    logic [IW-1:0]     idx_s;
    logic              err_s;
    logic              accept_s;
    logic              complete_s;
    logic [DWIDTH-1:0] cur_s;
    logic [DWIDTH-1:0] wmerge_s;
    logic [3:0]        ws_eff_s;
    logic              unused_s;

    assign idx_s = bus.haddr[2 +: IW];

    assign err_s = (|bus.haddr[AWIDTH-1:IW+2])
                 | (bus.hsize > 3'd2)
                 | ((bus.hsize == 3'd1) & bus.haddr[0])
                 | ((bus.hsize == 3'd2) & (bus.haddr[1:0] != 2'b00))
                 | (bus.hwrite & (idx_s == ACC_IDX));

    // New address phases are only sampled while this slave is presenting ready.
    assign accept_s   = ((state_r == ST_IDLE) | (state_r == ST_ERR2))
                      & bus.hsel & bus.hready & bus.htrans[1];
    assign complete_s = (state_r == ST_IDLE) & pend_r;
    assign unused_s   = bus.htrans[0];

    // Register word addressed by the transfer currently in its data phase.
    always_comb begin
        cur_s = {DWIDTH{1'b0}};
        if (idx_r == WS_IDX) begin
            cur_s = {{(DWIDTH-4){1'b0}}, ws_r};
        end else if (idx_r == ACC_IDX) begin
            cur_s = acc_r;
        end else begin
            cur_s = gp_r[idx_r];
        end
    end

    assign wmerge_s = merge_lanes(cur_s, bus.hwdata, mask_r);

    // A WS_CFG write completing this cycle already governs a transfer pipelined behind it.
    assign ws_eff_s = (complete_s & write_r & (idx_r == WS_IDX)) ? wmerge_s[3:0] : ws_r;

    assign bus.hrdata    = (complete_s & ~write_r) ? cur_s : {DWIDTH{1'b0}};
    assign bus.hreadyout = hreadyout_r;
    assign bus.hresp     = hresp_r;

    // Next-state and wait counter.
    always_comb begin
        state_n = state_r;
        cnt_n   = cnt_r;
        pend_n  = 1'b0;
        case (state_r)
            ST_IDLE, ST_ERR2: begin
                if (accept_s) begin
                    if (err_s) begin
                        state_n = ST_ERR1;
                    end else if (ws_eff_s == 4'd0) begin
                        state_n = ST_IDLE;
                        pend_n  = 1'b1;
                    end else begin
                        state_n = ST_WAIT;
                        cnt_n   = ws_eff_s - 4'd1;
                    end
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r == 4'd0) begin
                    state_n = ST_IDLE;
                    pend_n  = 1'b1;
                end else begin
                    cnt_n = cnt_r - 4'd1;
                end
            end
            ST_ERR1: begin
                state_n = ST_ERR2;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // State, captured address-phase fields and registered response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 4'd0;
            pend_r      <= 1'b0;
            idx_r       <= {IW{1'b0}};
            mask_r      <= 4'd0;
            write_r     <= 1'b0;
            hreadyout_r <= 1'b1;
            hresp_r     <= 1'b0;
        end else begin
            state_r     <= state_n;
            cnt_r       <= cnt_n;
            pend_r      <= pend_n;
            hreadyout_r <= (state_n != ST_WAIT) && (state_n != ST_ERR1);
            hresp_r     <= (state_n == ST_ERR1) || (state_n == ST_ERR2);
            if (accept_s && !err_s) begin
                idx_r   <= idx_s;
                mask_r  <= lane_mask(bus.hsize[1:0], bus.haddr[1:0]);
                write_r <= bus.hwrite;
            end
        end
    end

    // Register file and transfer counter, updated only in an OKAY completion cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            ws_r  <= 4'd0;
            acc_r <= {DWIDTH{1'b0}};
            for (int i = 0; i < NREGS; i++) begin
                gp_r[i] <= {DWIDTH{1'b0}};
            end
        end else if (complete_s) begin
            acc_r <= acc_r + {{(DWIDTH-1){1'b0}}, 1'b1};
            if (write_r && (idx_r == WS_IDX)) begin
                ws_r <= wmerge_s[3:0];
            end else if (write_r && (idx_r != ACC_IDX)) begin
                gp_r[idx_r] <= wmerge_s;
            end
        end
    end
endmodule
